// File: rtl/alu_seq_if.sv
// alu_seq_if: control and handshake bundle for the sequential ALU.
//   i_start        start request; op and operands sampled when accepted
//   i_op           operation select
//   i_data_a/b     operands
//   i_read_n       active-low read of the low result half onto the bus
//   i_read_hi_n    active-low read of the high product half onto the bus
//   i_read_flags_n active-low read of the flag set
//   o_busy         high while a multiply iterates
//   o_done         one-cycle completion pulse
// The tristate bus and flag outputs are plain ports on the ALU itself so that
// every bus participant resolves its drivers at its own module boundary.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_data_a;
  logic [WIDTH-1:0] i_data_b;
  logic             i_read_n;
  logic             i_read_hi_n;
  logic             i_read_flags_n;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_op, i_data_a, i_data_b, i_read_n, i_read_hi_n, i_read_flags_n,
    input  o_busy, o_done
  );

  modport slave (
    input  i_start, i_op, i_data_a, i_data_b, i_read_n, i_read_hi_n, i_read_flags_n,
    output o_busy, o_done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-function ALU sitting on the shared CPU data bus.
// Single-cycle ADD/SUB/AND/OR/XOR/SHL/SHR, multi-cycle shift-add MUL.
// All state updates on the falling edge of i_clk; i_reset is async active-high.
// Ports:
//   i_clk, i_reset  clock (falling edge active) and asynchronous reset
//   ctrl            alu_seq_if.slave: start/op/operands, read enables, busy/done
//   o_bus           shared data bus, driven only while a read enable is low
//   o_flags         {V,N,C,Z}, driven only while i_read_flags_n is low
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  alu_seq_if.slave         ctrl,
  inout  wire  [WIDTH-1:0] o_bus,
  output wire  [3:0]       o_flags
);

  if (WIDTH < 2) begin : g_width_check
    $error("alu_seq: WIDTH must be >= 2");
  end

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_lo_q, res_hi_q;
  logic [3:0]         flags_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_next;
  logic [CntW-1:0]    cnt_q;

  logic             accept, mul_last;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  assign accept   = ctrl.i_start && (state_q != StMul);
  assign mul_last = (state_q == StMul) && (cnt_q == CntW'(WIDTH - 1));

  // State register
  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = (ctrl.i_op == OpMul) ? StMul : StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StMul: begin
        if (mul_last) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    ctrl.o_busy = (state_q == StMul);
    ctrl.o_done = (state_q == StDone);
  end

  // Single-cycle operations
  always_comb begin
    sum     = {1'b0, ctrl.i_data_a} + {1'b0, ctrl.i_data_b};
    diff    = {1'b0, ctrl.i_data_a} - {1'b0, ctrl.i_data_b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (ctrl.i_op)
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        // Same-sign operands producing a different-sign result
        alu_v   = (ctrl.i_data_a[WIDTH-1] == ctrl.i_data_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != ctrl.i_data_a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];  // borrow out of the unsigned subtract
        alu_v   = (ctrl.i_data_a[WIDTH-1] != ctrl.i_data_b[WIDTH-1]) &&
                  (diff[WIDTH-1] != ctrl.i_data_a[WIDTH-1]);
      end
      OpAnd: alu_res = ctrl.i_data_a & ctrl.i_data_b;
      OpOr:  alu_res = ctrl.i_data_a | ctrl.i_data_b;
      OpXor: alu_res = ctrl.i_data_a ^ ctrl.i_data_b;
      OpShl: begin
        alu_res = {ctrl.i_data_a[WIDTH-2:0], 1'b0};
        alu_c   = ctrl.i_data_a[WIDTH-1];
      end
      OpShr: begin
        alu_res = {1'b0, ctrl.i_data_a[WIDTH-1:1]};
        alu_c   = ctrl.i_data_a[0];
      end
      default: ;  // MUL is handled by the iterative datapath
    endcase
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Datapath: results, flags and the shift-add multiplier
  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      if (ctrl.i_op == OpMul) begin
        mcand_q  <= {{WIDTH{1'b0}}, ctrl.i_data_a};
        mplier_q <= ctrl.i_data_b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else begin
        res_lo_q <= alu_res;
        res_hi_q <= '0;
        flags_q  <= {alu_v, alu_res[WIDTH-1], alu_c, (alu_res == '0)};
      end
    end else if (state_q == StMul) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
      if (mul_last) begin
        res_lo_q <= acc_next[WIDTH-1:0];
        res_hi_q <= acc_next[2*WIDTH-1:WIDTH];
        flags_q  <= {1'b0, acc_next[WIDTH-1], (acc_next[2*WIDTH-1:WIDTH] != '0),
                     (acc_next == '0)};
      end
    end
  end

  // Low half wins when both read enables are asserted
  assign o_bus   = !ctrl.i_read_n    ? res_lo_q :
                   !ctrl.i_read_hi_n ? res_hi_q : {WIDTH{1'bz}};
  assign o_flags = !ctrl.i_read_flags_n ? flags_q : 4'bzzzz;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int unsigned W = 8;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    int           cyc;
    string        name;
  } exp_t;

  logic         clk;
  logic         rst;
  wire  [W-1:0] bus;
  wire  [3:0]   flags;
  logic         mon_rd_n, mon_rd_hi_n, mon_rd_fl_n;
  logic         stim_rd_n, stim_rd_hi_n, stim_rd_fl_n;
  int           cyc;
  int           n_tests;
  int           n_fail;
  exp_t         exp_q[$];
  logic [W-1:0] zbus;
  logic [3:0]   zflags;

  alu_seq_if #(.WIDTH(W)) ctrl_if ();

  alu_seq #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .ctrl    (ctrl_if),
    .o_bus   (bus),
    .o_flags (flags)
  );

  // Monitor and stimulus each own a set of read enables; either can read.
  assign ctrl_if.i_read_n       = mon_rd_n & stim_rd_n;
  assign ctrl_if.i_read_hi_n    = mon_rd_hi_n & stim_rd_hi_n;
  assign ctrl_if.i_read_flags_n = mon_rd_fl_n & stim_rd_fl_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per o_done cycle and reads the results back
  always @(posedge clk) begin
    exp_t e;
    if (ctrl_if.o_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got o_done=1 at cycle %0d, want no completion", cyc);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_latency"}, cyc, e.cyc);
        mon_rd_n = 1'b0;
        #1 check({e.name, "_lo"}, {24'h0, bus}, {24'h0, e.lo});
        mon_rd_n    = 1'b1;
        mon_rd_hi_n = 1'b0;
        #1 check({e.name, "_hi"}, {24'h0, bus}, {24'h0, e.hi});
        mon_rd_hi_n = 1'b1;
        mon_rd_fl_n = 1'b0;
        #1 check({e.name, "_flags"}, {28'h0, flags}, {28'h0, e.fl});
        mon_rd_fl_n = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; start is held across exactly one falling edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [3:0] fl,
                       input int lat, input string name);
    exp_t e;
    e.lo = lo; e.hi = hi; e.fl = fl; e.cyc = cyc + lat; e.name = name;
    exp_q.push_back(e);
    ctrl_if.i_start  = 1'b1;
    ctrl_if.i_op     = op;
    ctrl_if.i_data_a = a;
    ctrl_if.i_data_b = b;
    step();
    ctrl_if.i_start = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      #4;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d responses pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int busy_n;
    int done_n;
    n_tests = 0;
    n_fail  = 0;
    zbus    = 'z;
    zflags  = 'z;
    rst = 1'b1;
    {mon_rd_n, mon_rd_hi_n, mon_rd_fl_n}    = 3'b111;
    {stim_rd_n, stim_rd_hi_n, stim_rd_fl_n} = 3'b111;
    ctrl_if.i_start  = 1'b0;
    ctrl_if.i_op     = OpAdd;
    ctrl_if.i_data_a = '0;
    ctrl_if.i_data_b = '0;

    // Reset state
    repeat (2) step();
    check("rst_busy", {31'h0, ctrl_if.o_busy}, 32'h0);
    check("rst_done", {31'h0, ctrl_if.o_done}, 32'h0);
    stim_rd_n = 1'b0;
    #1 check("rst_bus", {24'h0, bus}, 32'h0);
    stim_rd_n    = 1'b1;
    stim_rd_fl_n = 1'b0;
    #1 check("rst_flags", {28'h0, flags}, 32'h0);
    stim_rd_fl_n = 1'b1;
    rst = 1'b0;

    // Flags are {V,N,C,Z}
    step(); issue(OpAdd, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 1, "add_ff_01"); drain("add_ff_01");
    step(); issue(OpSub, 8'h05, 8'h07, 8'hFE, 8'h00, 4'b0110, 1, "sub_05_07"); drain("sub_05_07");
    step(); issue(OpAdd, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1100, 1, "add_7f_01"); drain("add_7f_01");
    step(); issue(OpSub, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b1000, 1, "sub_80_01"); drain("sub_80_01");

    // MUL 0xFF*0xFF = 0xFE01; a start pulse mid-iteration must be ignored
    step(); issue(OpMul, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0010, W + 1, "mul_ff_ff");
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (ctrl_if.o_done === 1'b1) break;
      if (ctrl_if.o_busy === 1'b1) busy_n++;
      if (k == 3) begin
        ctrl_if.i_start  = 1'b1;
        ctrl_if.i_op     = OpAdd;
        ctrl_if.i_data_a = 8'h12;
        ctrl_if.i_data_b = 8'h34;
      end else begin
        ctrl_if.i_start = 1'b0;
      end
      step();
    end
    ctrl_if.i_start = 1'b0;
    check("mul_busy_edges", busy_n, W);
    drain("mul_ff_ff");

    // Z reflects the full product, C any high-half bit
    step(); issue(OpMul, 8'h10, 8'h10, 8'h00, 8'h01, 4'b0010, W + 1, "mul_10_10"); drain("mul_10_10");
    step(); issue(OpMul, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0001, W + 1, "mul_00_37"); drain("mul_00_37");

    step(); issue(OpShl, 8'h81, 8'hAA, 8'h02, 8'h00, 4'b0010, 1, "shl_81"); drain("shl_81");
    step(); issue(OpShr, 8'h01, 8'hAA, 8'h00, 8'h00, 4'b0011, 1, "shr_01"); drain("shr_01");
    step(); issue(OpAnd, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1, "and_f0_3c"); drain("and_f0_3c");
    step(); issue(OpOr,  8'hF0, 8'h3C, 8'hFC, 8'h00, 4'b0100, 1, "or_f0_3c"); drain("or_f0_3c");
    step(); issue(OpXor, 8'hF0, 8'h3C, 8'hCC, 8'h00, 4'b0100, 1, "xor_f0_3c"); drain("xor_f0_3c");

    // Bus contention and release
    step();
    check("idle_bus_z", {24'h0, bus}, {24'h0, zbus});
    check("idle_flags_z", {28'h0, flags}, {28'h0, zflags});
    stim_rd_n    = 1'b0;
    stim_rd_hi_n = 1'b0;
    #1 check("both_rd_lo_wins", {24'h0, bus}, 32'hCC);
    stim_rd_n = 1'b1;
    #1 check("hi_rd_only", {24'h0, bus}, 32'h00);
    stim_rd_hi_n = 1'b1;
    stim_rd_fl_n = 1'b0;
    #1 check("flags_rd_only", {28'h0, flags}, 32'h4);
    stim_rd_fl_n = 1'b1;

    // Reset after the 4th MUL edge abandons the multiply
    step();
    ctrl_if.i_start  = 1'b1;
    ctrl_if.i_op     = OpMul;
    ctrl_if.i_data_a = 8'h0F;
    ctrl_if.i_data_b = 8'h0F;
    step();
    ctrl_if.i_start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("pre_rst_busy", {31'h0, ctrl_if.o_busy}, 32'h1);
    rst = 1'b1;
    #1 check("mid_rst_busy", {31'h0, ctrl_if.o_busy}, 32'h0);
    check("mid_rst_done", {31'h0, ctrl_if.o_done}, 32'h0);
    stim_rd_n = 1'b0;
    #1 check("mid_rst_bus", {24'h0, bus}, 32'h0);
    stim_rd_n    = 1'b1;
    stim_rd_fl_n = 1'b0;
    #1 check("mid_rst_flags", {28'h0, flags}, 32'h0);
    stim_rd_fl_n = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    done_n = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (ctrl_if.o_done === 1'b1) done_n++;
    end
    check("abandoned_mul_no_done", done_n, 0);

    // Back-to-back: the second ADD is accepted while the first is in DONE
    step();
    issue(OpAdd, 8'h01, 8'h02, 8'h03, 8'h00, 4'b0000, 1, "b2b_add_1");
    issue(OpAdd, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1011, 1, "b2b_add_2");
    drain("b2b_add");
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
